tft_disp_ctrl: RTL

TFT_DISP_CTRL -- requirements
Module: tft_disp_ctrl

---
 rtl/tft_pkg.sv | 30 +++
 rtl/tft_pix_fmt.sv | 31 +++
 rtl/tft_disp_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tft_pkg.sv
// Shared TFT display definitions: output mode encodings and the colour-bar table.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package tft_pkg;

    // Output source selection, latched once per frame by the controller.
    typedef enum logic [1:0] {
        MODE_PASS      = 2'd0,   // RGB565 pixels from the frame-buffer read FIFO
        MODE_BAR       = 2'd1,   // built-in 8-bar test pattern
        MODE_BLACK     = 2'd2,   // solid black
        MODE_BLACK_ALT = 2'd3    // spare code, also solid black
    } mode_e;

    localparam int BAR_NUM = 8;

    localparam logic [23:0] RGB_BLACK = 24'h000000;

    // Colour-bar palette, element 0 is the leftmost bar.
    localparam logic [BAR_NUM-1:0][23:0] BAR_TABLE = {
        24'h000000,   // bar 7: black
        24'h0000FF,   // bar 6: blue
        24'hFF0000,   // bar 5: red
        24'hFF00FF,   // bar 4: magenta
        24'h00FF00,   // bar 3: green
        24'h00FFFF,   // bar 2: cyan
        24'hFFFF00,   // bar 1: yellow
        24'hFFFFFF    // bar 0: white
    };

endpackage

// File: rtl/tft_pix_fmt.sv
// Pixel formatter: RGB565 to RGB888 expansion, colour-bar lookup and black fill.
// Latency: purely combinational; the parent registers the result.
// Backpressure: none; an empty FIFO read is flagged by empty_i and shown as black.
module tft_pix_fmt
    import tft_pkg::*;
(
    input  logic [1:0]  mode_i,
    input  logic [15:0] rgb565_i,
    input  logic        empty_i,
    input  logic [2:0]  bar_idx_i,
    output logic [23:0] rgb_o
);

    logic [23:0] rgb888;

    // MSB replication fills the low bits so full-scale 565 maps to full-scale 888.
    assign rgb888 = {rgb565_i[15:11], rgb565_i[15:13],
                     rgb565_i[10:5],  rgb565_i[10:9],
                     rgb565_i[4:0],   rgb565_i[4:2]};

    // Select the pixel source for the current mode.
    always_comb begin
        rgb_o = RGB_BLACK;
        case (mode_e'(mode_i))
            MODE_PASS: rgb_o = empty_i ? RGB_BLACK : rgb888;
            MODE_BAR:  rgb_o = BAR_TABLE[bar_idx_i];
            default:   rgb_o = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/tft_disp_ctrl.sv
// TFT display timing controller: sync/DE generation, FIFO read strobes, pixel output.
// Latency: counters -> data_req 1 cycle; counters -> hs/vs/de/rgb 3 cycles (de = data_req + 2).
// Backpressure: none; reads are issued for every active pixel, an empty FIFO gives black + sticky underflow.
module tft_disp_ctrl
    import tft_pkg::*;
#(
    parameter int   H_SYNC  = 96,
    parameter int   H_BACK  = 48,
    parameter int   H_VALID = 640,
    parameter int   H_FRONT = 16,
    parameter int   V_SYNC  = 2,
    parameter int   V_BACK  = 33,
    parameter int   V_VALID = 480,
    parameter int   V_FRONT = 10,
    parameter logic HS_POL  = 1'b1,
    parameter logic VS_POL  = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  mode,
    input  logic [15:0] data_in,
    input  logic        data_empty,
    output logic        data_req,
    output logic        tft_clk,
    output logic [23:0] tft_rgb,
    output logic        tft_hs,
    output logic        tft_vs,
    output logic        tft_de,
    output logic        tft_bl,
    output logic        frame_start,
    output logic        underflow,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    // One spare count of headroom so the end-of-active bound always fits.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] HC_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HC_SYNC = HW'(H_SYNC);
    localparam logic [HW-1:0] HC_ACT0 = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] HC_ACT1 = HW'(H_SYNC + H_BACK + H_VALID);
    localparam logic [VW-1:0] VC_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VC_SYNC = VW'(V_SYNC);
    localparam logic [VW-1:0] VC_ACT0 = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] VC_ACT1 = VW'(V_SYNC + V_BACK + V_VALID);

    // Colour bars are H_VALID/8 pixels wide; a pixel counter within the bar
    // avoids a divider on the horizontal position.
    localparam int BAR_W = H_VALID / BAR_NUM;
    localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BPW-1:0] BP_LAST = BPW'(BAR_W - 1);

    // ---------------- stage 0: counters and control ----------------
    logic          run_q;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          fs_d;
    logic          frame_start_q;
    logic [15:0]   frame_cnt_q;
    logic [1:0]    mode_q;
    logic          underflow_q, underflow_d;
    logic          uf_set;

    logic          h_act_c, v_act_c, act_c, line_first_c;
    logic          hs_c, vs_c;

    // ---------------- stage 1: read strobe cycle ----------------
    logic           data_req_q;
    logic           hs1_q, vs1_q;
    logic [BPW-1:0] bar_px_q, bar_px_d;
    logic [2:0]     bar_idx_q, bar_idx_d;

    // ---------------- stage 2: FIFO data cycle ----------------
    logic           de2_q, hs2_q, vs2_q, empty2_q;
    logic [2:0]     bar2_q;
    logic [23:0]    pix_rgb;

    // ---------------- output registers ----------------
    logic           tft_de_q, tft_hs_q, tft_vs_q;
    logic [23:0]    tft_rgb_q;

    // Pixel clock goes straight to the panel.
    assign tft_clk = sys_clk;

    // Region decode from the live counters; nothing is active until the first
    // post-reset edge has parked the counters at (0,0).
    assign h_act_c      = (h_cnt_q >= HC_ACT0) && (h_cnt_q < HC_ACT1);
    assign v_act_c      = (v_cnt_q >= VC_ACT0) && (v_cnt_q < VC_ACT1);
    assign act_c        = run_q && h_act_c && v_act_c;
    assign line_first_c = (h_cnt_q == HC_ACT0);
    assign hs_c         = (run_q && (h_cnt_q < HC_SYNC)) ? HS_POL : ~HS_POL;
    assign vs_c         = (run_q && (v_cnt_q < VC_SYNC)) ? VS_POL : ~VS_POL;

    // Next counter position; fs_d flags that the next cycle sits at (0,0).
    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        fs_d        = 1'b0;
        if (!run_q) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            fs_d    = 1'b1;
        end else if (h_cnt_q == HC_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == VC_LAST) begin
                v_cnt_d = '0;
                fs_d    = 1'b1;
            end else begin
                v_cnt_d = v_cnt_q + 1'b1;
            end
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end
        // A read against an empty FIFO wins over the frame-start clear.
        uf_set      = data_req_q & data_empty;
        underflow_d = uf_set | (underflow_q & ~fs_d);
    end

    // Timing counters, start-up flag, frame pulse/counter, latched mode, underflow.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            run_q         <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            mode_q        <= MODE_PASS;
            underflow_q   <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= fs_d;
            underflow_q   <= underflow_d;
            if (fs_d) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            // Mode only changes while the counters sit at (0,0); the porches
            // drain the previous frame's pixels before the new mode reaches them.
            if (frame_start_q) begin
                mode_q <= mode;
            end
        end
    end

    // Bar position of the pixel being read, restarted at each line's first pixel.
    always_comb begin
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;
        if (act_c) begin
            if (line_first_c) begin
                bar_px_d  = '0;
                bar_idx_d = '0;
            end else if (bar_px_q == BP_LAST) begin
                bar_px_d  = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d  = bar_px_q + 1'b1;
            end
        end
    end

    // Stage 1: FIFO read strobe plus the sync levels and bar index that travel with it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_req_q <= 1'b0;
            hs1_q      <= ~HS_POL;
            vs1_q      <= ~VS_POL;
            bar_px_q   <= '0;
            bar_idx_q  <= '0;
        end else begin
            data_req_q <= act_c;
            hs1_q      <= hs_c;
            vs1_q      <= vs_c;
            bar_px_q   <= bar_px_d;
            bar_idx_q  <= bar_idx_d;
        end
    end

    // Stage 2: the cycle in which the FIFO presents data_in for the strobe above.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            de2_q    <= 1'b0;
            hs2_q    <= ~HS_POL;
            vs2_q    <= ~VS_POL;
            empty2_q <= 1'b0;
            bar2_q   <= '0;
        end else begin
            de2_q    <= data_req_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            empty2_q <= uf_set;
            bar2_q   <= bar_idx_q;
        end
    end

    tft_pix_fmt u_pix_fmt (
        .mode_i    (mode_q),
        .rgb565_i  (data_in),
        .empty_i   (empty2_q),
        .bar_idx_i (bar2_q),
        .rgb_o     (pix_rgb)
    );

    // Output registers: data_in is captured here, aligned with hs/vs/de; blanking forces black.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tft_de_q  <= 1'b0;
            tft_hs_q  <= ~HS_POL;
            tft_vs_q  <= ~VS_POL;
            tft_rgb_q <= '0;
        end else begin
            tft_de_q  <= de2_q;
            tft_hs_q  <= hs2_q;
            tft_vs_q  <= vs2_q;
            tft_rgb_q <= de2_q ? pix_rgb : RGB_BLACK;
        end
    end

    assign data_req    = data_req_q;
    assign tft_rgb     = tft_rgb_q;
    assign tft_hs      = tft_hs_q;
    assign tft_vs      = tft_vs_q;
    assign tft_de      = tft_de_q;
    assign tft_bl      = run_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
